// File: rtl/mem_bus_arbiter_pkg.sv
// Shared types for the processor-memory port arbiter.
// Bus command encoding, tag width and request owner identifiers.
package mem_bus_arbiter_pkg;
    localparam int XLEN      = 32;
    localparam int MEM_TAG_W = 4;

    typedef enum logic [1:0] {
        BUS_NONE  = 2'h0,
        BUS_LOAD  = 2'h1,
        BUS_STORE = 2'h2
    } BUS_COMMAND;

    typedef enum logic {
        OWN_IC = 1'b0,
        OWN_DC = 1'b1
    } OWNER_T;
endpackage

// File: rtl/mem_bus_arbiter_if.sv
// Cache-side and memory-side signals of the shared memory port.
// master is the arbiter's view, slave is the caches/memory view.
interface mem_bus_arbiter_if;
    import mem_bus_arbiter_pkg::*;

    logic                 ic_req_valid;
    logic [XLEN-1:0]      ic_req_addr;
    logic                 ic_req_accept;
    logic [MEM_TAG_W-1:0] ic_req_tag;
    logic                 ic_resp_valid;
    logic [MEM_TAG_W-1:0] ic_resp_tag;
    logic [63:0]          ic_resp_data;

    BUS_COMMAND           dc_req_command;
    logic [XLEN-1:0]      dc_req_addr;
    logic [63:0]          dc_req_data;
    logic                 dc_req_accept;
    logic [MEM_TAG_W-1:0] dc_req_tag;
    logic                 dc_resp_valid;
    logic [MEM_TAG_W-1:0] dc_resp_tag;
    logic [63:0]          dc_resp_data;
    logic                 dc_owns_bus;

    BUS_COMMAND           proc2mem_command;
    logic [XLEN-1:0]      proc2mem_addr;
    logic [63:0]          proc2mem_data;
    logic [MEM_TAG_W-1:0] mem2proc_response;
    logic [63:0]          mem2proc_data;
    logic [MEM_TAG_W-1:0] mem2proc_tag;

    logic [4:0]           outstanding;
    logic                 tag_err;

    modport master (
        input  ic_req_valid, ic_req_addr,
        input  dc_req_command, dc_req_addr, dc_req_data,
        input  mem2proc_response, mem2proc_data, mem2proc_tag,
        output ic_req_accept, ic_req_tag,
        output ic_resp_valid, ic_resp_tag, ic_resp_data,
        output dc_req_accept, dc_req_tag,
        output dc_resp_valid, dc_resp_tag, dc_resp_data,
        output dc_owns_bus,
        output proc2mem_command, proc2mem_addr, proc2mem_data,
        output outstanding, tag_err
    );

    modport slave (
        output ic_req_valid, ic_req_addr,
        output dc_req_command, dc_req_addr, dc_req_data,
        output mem2proc_response, mem2proc_data, mem2proc_tag,
        input  ic_req_accept, ic_req_tag,
        input  ic_resp_valid, ic_resp_tag, ic_resp_data,
        input  dc_req_accept, dc_req_tag,
        input  dc_resp_valid, dc_resp_tag, dc_resp_data,
        input  dc_owns_bus,
        input  proc2mem_command, proc2mem_addr, proc2mem_data,
        input  outstanding, tag_err
    );
endinterface

// File: rtl/mem_tag_table.sv
// Owner table for outstanding memory tags: valid bit plus owning cache.
// Tag 0 is never valid, so a lookup of "no tag" always misses.
module mem_tag_table
    import mem_bus_arbiter_pkg::*;
#(
    parameter int NUM_TAGS = 15
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic                 alloc_en,
    input  logic [MEM_TAG_W-1:0] alloc_tag,
    input  OWNER_T               alloc_owner,
    input  logic                 free_en,
    input  logic [MEM_TAG_W-1:0] free_tag,
    input  logic [MEM_TAG_W-1:0] lookup_tag,
    output logic                 lookup_valid,
    output OWNER_T               lookup_owner,
    output logic [4:0]           count
);
    logic [NUM_TAGS:0] valid_q, valid_d;
    logic [NUM_TAGS:0] owner_q, owner_d;

    always_comb begin
        valid_d = valid_q;
        owner_d = owner_q;
        if (free_en) begin
            valid_d[free_tag] = 1'b0;
        end
        // Allocation after free: a reused tag keeps the new owner.
        if (alloc_en) begin
            valid_d[alloc_tag] = 1'b1;
            owner_d[alloc_tag] = alloc_owner;
        end
        valid_d[0] = 1'b0;
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            valid_q <= '0;
            owner_q <= '0;
        end else begin
            valid_q <= valid_d;
            owner_q <= owner_d;
        end
    end

    assign lookup_valid = valid_q[lookup_tag];
    assign lookup_owner = OWNER_T'(owner_q[lookup_tag]);
    assign count        = 5'($countones(valid_q));
endmodule

// File: rtl/mem_bus_arbiter.sv
// Arbitrates the memory port between I-cache fills and D-cache accesses.
// D-cache has priority; a starved fetch request wins after STARVE_LIMIT losses.
module mem_bus_arbiter
    import mem_bus_arbiter_pkg::*;
#(
    parameter int STARVE_LIMIT = 4,
    parameter int NUM_TAGS     = 15
) (
    input logic              clock,
    input logic              reset,
    mem_bus_arbiter_if.master bus
);
    localparam int SW = $clog2(STARVE_LIMIT + 1);

    logic [SW-1:0] starve_cnt_q, starve_cnt_d;
    logic          tag_err_q, tag_err_d;

    logic   ic_want, dc_want, ic_sel, dc_sel;
    logic   mem_acc, ic_acc, dc_acc;
    logic   alloc_en;
    OWNER_T alloc_owner;
    logic   ret_valid, ret_hit, lk_valid;
    OWNER_T lk_owner;
    logic [4:0] count;

    always_comb begin
        ic_want = bus.ic_req_valid;
        dc_want = bus.dc_req_command != BUS_NONE;
        ic_sel  = ic_want &&
                  (!dc_want || starve_cnt_q == SW'(STARVE_LIMIT));
        dc_sel  = dc_want && !ic_sel;
        mem_acc = bus.mem2proc_response != '0;
        ic_acc  = ic_sel && mem_acc;
        dc_acc  = dc_sel && mem_acc;

        bus.proc2mem_command = BUS_NONE;
        bus.proc2mem_addr    = '0;
        bus.proc2mem_data    = '0;
        if (ic_sel) begin
            bus.proc2mem_command = BUS_LOAD;
            bus.proc2mem_addr    = bus.ic_req_addr;
        end else if (dc_sel) begin
            bus.proc2mem_command = bus.dc_req_command;
            bus.proc2mem_addr    = bus.dc_req_addr;
            bus.proc2mem_data    = bus.dc_req_data;
        end

        bus.dc_owns_bus   = dc_sel;
        bus.ic_req_accept = ic_acc;
        bus.dc_req_accept = dc_acc;
        bus.ic_req_tag    = ic_acc ? bus.mem2proc_response : '0;
        bus.dc_req_tag    = dc_acc ? bus.mem2proc_response : '0;

        // Stores return nothing, so only loads take a table entry.
        alloc_en    = ic_acc ||
                      (dc_acc && bus.dc_req_command == BUS_LOAD);
        alloc_owner = dc_sel ? OWN_DC : OWN_IC;
    end

    always_comb begin
        ret_valid = bus.mem2proc_tag != '0;
        ret_hit   = ret_valid && lk_valid;

        bus.ic_resp_valid = ret_hit && lk_owner == OWN_IC;
        bus.dc_resp_valid = ret_hit && lk_owner == OWN_DC;
        bus.ic_resp_tag   = '0;
        bus.ic_resp_data  = '0;
        bus.dc_resp_tag   = '0;
        bus.dc_resp_data  = '0;
        if (ret_hit && lk_owner == OWN_IC) begin
            bus.ic_resp_tag  = bus.mem2proc_tag;
            bus.ic_resp_data = bus.mem2proc_data;
        end
        if (ret_hit && lk_owner == OWN_DC) begin
            bus.dc_resp_tag  = bus.mem2proc_tag;
            bus.dc_resp_data = bus.mem2proc_data;
        end

        tag_err_d = tag_err_q || (ret_valid && !lk_valid);

        starve_cnt_d = starve_cnt_q;
        if (!bus.ic_req_valid || ic_acc) begin
            starve_cnt_d = '0;
        end else if (starve_cnt_q != SW'(STARVE_LIMIT)) begin
            starve_cnt_d = starve_cnt_q + SW'(1);
        end

        bus.outstanding = count;
        bus.tag_err     = tag_err_q;
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            starve_cnt_q <= '0;
            tag_err_q    <= 1'b0;
        end else begin
            starve_cnt_q <= starve_cnt_d;
            tag_err_q    <= tag_err_d;
        end
    end

    mem_tag_table #(
        .NUM_TAGS(NUM_TAGS)
    ) u_tag_table (
        .clock       (clock),
        .reset       (reset),
        .alloc_en    (alloc_en),
        .alloc_tag   (bus.mem2proc_response),
        .alloc_owner (alloc_owner),
        .free_en     (ret_hit),
        .free_tag    (bus.mem2proc_tag),
        .lookup_tag  (bus.mem2proc_tag),
        .lookup_valid(lk_valid),
        .lookup_owner(lk_owner),
        .count       (count)
    );
endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Scenario tests plus randomized traffic for mem_bus_arbiter.
// Expected values come from a tag-array reference model kept in the bench.
module tb_mem_bus_arbiter;
    import mem_bus_arbiter_pkg::*;

    localparam int LIMIT = 4;

    logic clock;
    logic reset;
    mem_bus_arbiter_if bus();

    mem_bus_arbiter #(
        .STARVE_LIMIT(LIMIT),
        .NUM_TAGS    (15)
    ) dut (
        .clock(clock),
        .reset(reset),
        .bus  (bus)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    int errs = 0;
    int checks = 0;

    // Reference model state
    bit mv[16];
    bit mo[16];
    int ms;
    bit merr;

    // Model expectations for the current cycle
    int          w;
    logic [1:0]  e_cmd;
    logic [31:0] e_addr;
    logic [63:0] e_pdata;
    logic        e_ica, e_dca, e_own;
    logic [3:0]  e_ict, e_dct;
    logic        e_icr, e_dcr;
    logic [3:0]  e_icrt, e_dcrt;
    logic [63:0] e_icrd, e_dcrd;
    logic [4:0]  e_out;
    logic        e_err;
    logic        hit;
    logic [3:0]  m_rt, m_rsp;

    task automatic model_clear();
        for (int i = 0; i < 16; i++) begin
            mv[i] = 1'b0;
            mo[i] = 1'b0;
        end
        ms = 0;
        merr = 1'b0;
    endtask

    task automatic model_eval();
        bit icv, dcv;
        icv = bus.ic_req_valid;
        dcv = bus.dc_req_command != BUS_NONE;
        if (icv && (!dcv || ms == LIMIT)) w = 1;
        else if (dcv) w = 2;
        else w = 0;
        e_cmd   = (w == 1) ? 2'd1 : (w == 2) ? bus.dc_req_command : 2'd0;
        e_addr  = (w == 1) ? bus.ic_req_addr :
                  (w == 2) ? bus.dc_req_addr : 32'h0;
        e_pdata = (w == 2) ? bus.dc_req_data : 64'h0;
        m_rsp   = bus.mem2proc_response;
        e_ica   = (w == 1) && (m_rsp != 0);
        e_dca   = (w == 2) && (m_rsp != 0);
        e_ict   = e_ica ? m_rsp : 4'h0;
        e_dct   = e_dca ? m_rsp : 4'h0;
        e_own   = (w == 2);
        m_rt    = bus.mem2proc_tag;
        hit     = (m_rt != 0) && mv[m_rt];
        e_icr   = hit && !mo[m_rt];
        e_dcr   = hit && mo[m_rt];
        e_icrt  = e_icr ? m_rt : 4'h0;
        e_dcrt  = e_dcr ? m_rt : 4'h0;
        e_icrd  = e_icr ? bus.mem2proc_data : 64'h0;
        e_dcrd  = e_dcr ? bus.mem2proc_data : 64'h0;
        e_out   = 5'd0;
        for (int i = 1; i < 16; i++) e_out = e_out + 5'(mv[i]);
        e_err   = merr;
    endtask

    task automatic model_commit();
        if (m_rt != 0 && !mv[m_rt]) merr = 1'b1;
        if (hit) mv[m_rt] = 1'b0;
        if (e_ica || (e_dca && bus.dc_req_command == BUS_LOAD)) begin
            mv[m_rsp] = 1'b1;
            mo[m_rsp] = (w == 2);
        end
        if (!bus.ic_req_valid || e_ica) ms = 0;
        else if (ms < LIMIT) ms++;
    endtask

    task automatic idle();
        bus.ic_req_valid      = 1'b0;
        bus.ic_req_addr       = '0;
        bus.dc_req_command    = BUS_NONE;
        bus.dc_req_addr       = '0;
        bus.dc_req_data       = '0;
        bus.mem2proc_response = '0;
        bus.mem2proc_data     = '0;
        bus.mem2proc_tag      = '0;
    endtask

    task automatic step();
        model_eval();
        model_commit();
        @(posedge clock);
        #1;
    endtask

    task automatic do_reset();
        idle();
        reset = 1'b1;
        model_clear();
        @(posedge clock);
        #1;
        reset = 1'b0;
    endtask

    task automatic test_reset();
        idle();
        reset = 1'b1;
        model_clear();
        @(posedge clock);
        #1;
        checks++;
        if (bus.outstanding !== 5'd0) begin
            errs++;
            $display("FAIL reset_outstanding: got %0d want 0", bus.outstanding);
        end
        checks++;
        if (bus.tag_err !== 1'b0) begin
            errs++;
            $display("FAIL reset_tag_err: got %0b want 0", bus.tag_err);
        end
        checks++;
        if ({bus.proc2mem_command, bus.proc2mem_addr, bus.proc2mem_data} !== '0) begin
            errs++;
            $display("FAIL reset_bus: got cmd %0d addr %0h want all 0",
                     bus.proc2mem_command, bus.proc2mem_addr);
        end
        checks++;
        if ({bus.ic_req_accept, bus.dc_req_accept, bus.dc_owns_bus,
             bus.ic_resp_valid, bus.dc_resp_valid} !== 5'b0) begin
            errs++;
            $display("FAIL reset_ctrl: got %b want 00000",
                     {bus.ic_req_accept, bus.dc_req_accept, bus.dc_owns_bus,
                      bus.ic_resp_valid, bus.dc_resp_valid});
        end
        reset = 1'b0;
        step();
    endtask

    task automatic test_dc_load();
        do_reset();
        bus.dc_req_command    = BUS_LOAD;
        bus.dc_req_addr       = 32'h100;
        bus.mem2proc_response = 4'd3;
        #1;
        checks++;
        if ({bus.dc_req_accept, bus.dc_req_tag} !== {1'b1, 4'd3}) begin
            errs++;
            $display("FAIL dc_load_accept: got acc %0b tag %0d want 1/3",
                     bus.dc_req_accept, bus.dc_req_tag);
        end
        checks++;
        if ({bus.proc2mem_command, bus.proc2mem_addr} !== {BUS_LOAD, 32'h100}) begin
            errs++;
            $display("FAIL dc_load_bus: got %0d/%0h want 1/100",
                     bus.proc2mem_command, bus.proc2mem_addr);
        end
        step();
        idle();
        #1;
        checks++;
        if (bus.outstanding !== 5'd1) begin
            errs++;
            $display("FAIL dc_load_out1: got %0d want 1", bus.outstanding);
        end
        step();
        bus.mem2proc_tag  = 4'd3;
        bus.mem2proc_data = 64'hDEAD_BEEF_0123_4567;
        #1;
        checks++;
        if ({bus.dc_resp_valid, bus.dc_resp_tag, bus.dc_resp_data, bus.ic_resp_valid}
            !== {1'b1, 4'd3, 64'hDEAD_BEEF_0123_4567, 1'b0}) begin
            errs++;
            $display("FAIL dc_load_resp: got v%0b t%0d d%0h icv%0b want 1/3/deadbeef01234567/0",
                     bus.dc_resp_valid, bus.dc_resp_tag, bus.dc_resp_data, bus.ic_resp_valid);
        end
        step();
        idle();
        #1;
        checks++;
        if (bus.outstanding !== 5'd0) begin
            errs++;
            $display("FAIL dc_load_out0: got %0d want 0", bus.outstanding);
        end
        step();
    endtask

    task automatic test_starve();
        do_reset();
        for (int i = 0; i < 10; i++) begin
            bus.ic_req_valid      = 1'b1;
            bus.ic_req_addr       = 32'h1000 + 32'(i * 8);
            bus.dc_req_command    = BUS_LOAD;
            bus.dc_req_addr       = 32'h2000 + 32'(i * 8);
            bus.mem2proc_response = 4'((i % 15) + 1);
            #1;
            checks++;
            if (bus.dc_owns_bus !== ((i % 5) != 4)) begin
                errs++;
                $display("FAIL starve_dc_owns c%0d: got %0b want %0b",
                         i, bus.dc_owns_bus, (i % 5) != 4);
            end
            checks++;
            if (bus.ic_req_accept !== ((i % 5) == 4)) begin
                errs++;
                $display("FAIL starve_ic_acc c%0d: got %0b want %0b",
                         i, bus.ic_req_accept, (i % 5) == 4);
            end
            step();
        end
        idle();
    endtask

    task automatic test_store();
        do_reset();
        bus.dc_req_command    = BUS_STORE;
        bus.dc_req_addr       = 32'h380;
        bus.dc_req_data       = 64'h5555_AAAA_1234_5678;
        bus.mem2proc_response = 4'd5;
        #1;
        checks++;
        if ({bus.dc_req_accept, bus.dc_req_tag, bus.proc2mem_command, bus.proc2mem_data}
            !== {1'b1, 4'd5, BUS_STORE, 64'h5555_AAAA_1234_5678}) begin
            errs++;
            $display("FAIL store_accept: got acc %0b tag %0d cmd %0d data %0h",
                     bus.dc_req_accept, bus.dc_req_tag, bus.proc2mem_command,
                     bus.proc2mem_data);
        end
        step();
        idle();
        #1;
        checks++;
        if (bus.outstanding !== 5'd0) begin
            errs++;
            $display("FAIL store_out: got %0d want 0", bus.outstanding);
        end
        bus.mem2proc_tag  = 4'd5;
        bus.mem2proc_data = 64'h77;
        #1;
        checks++;
        if ({bus.ic_resp_valid, bus.dc_resp_valid} !== 2'b00) begin
            errs++;
            $display("FAIL store_noresp: got %b want 00",
                     {bus.ic_resp_valid, bus.dc_resp_valid});
        end
        step();
        idle();
        #1;
        checks++;
        if (bus.tag_err !== 1'b1) begin
            errs++;
            $display("FAIL store_tag_err: got %0b want 1", bus.tag_err);
        end
        step();
    endtask

    task automatic test_reject();
        do_reset();
        for (int i = 0; i < 4; i++) begin
            bus.ic_req_valid      = 1'b1;
            bus.ic_req_addr       = 32'h208;
            bus.mem2proc_response = (i == 3) ? 4'd9 : 4'd0;
            #1;
            checks++;
            if ({bus.ic_req_accept, bus.ic_req_tag} !== ((i == 3) ? {1'b1, 4'd9} : 5'd0)) begin
                errs++;
                $display("FAIL reject_acc c%0d: got %0b/%0d want %0b/%0d",
                         i, bus.ic_req_accept, bus.ic_req_tag,
                         i == 3, (i == 3) ? 9 : 0);
            end
            checks++;
            if ({bus.proc2mem_command, bus.proc2mem_addr, bus.proc2mem_data}
                !== {BUS_LOAD, 32'h208, 64'h0}) begin
                errs++;
                $display("FAIL reject_bus c%0d: got %0d/%0h want 1/208",
                         i, bus.proc2mem_command, bus.proc2mem_addr);
            end
            step();
        end
        idle();
    endtask

    task automatic test_same_tag();
        do_reset();
        bus.ic_req_valid      = 1'b1;
        bus.ic_req_addr       = 32'h40;
        bus.mem2proc_response = 4'd7;
        step();
        idle();
        bus.dc_req_command    = BUS_LOAD;
        bus.dc_req_addr       = 32'h300;
        bus.mem2proc_response = 4'd7;
        bus.mem2proc_tag      = 4'd7;
        bus.mem2proc_data     = 64'h1111_2222_3333_4444;
        #1;
        checks++;
        if ({bus.ic_resp_valid, bus.ic_resp_tag, bus.ic_resp_data, bus.dc_resp_valid,
             bus.dc_req_accept}
            !== {1'b1, 4'd7, 64'h1111_2222_3333_4444, 1'b0, 1'b1}) begin
            errs++;
            $display("FAIL same_tag_ret: got icv%0b t%0d d%0h dcv%0b acc%0b",
                     bus.ic_resp_valid, bus.ic_resp_tag, bus.ic_resp_data,
                     bus.dc_resp_valid, bus.dc_req_accept);
        end
        step();
        idle();
        bus.mem2proc_tag  = 4'd7;
        bus.mem2proc_data = 64'h9999;
        #1;
        checks++;
        if ({bus.dc_resp_valid, bus.ic_resp_valid, bus.outstanding}
            !== {1'b1, 1'b0, 5'd1}) begin
            errs++;
            $display("FAIL same_tag_owner: got dcv%0b icv%0b out%0d want 1/0/1",
                     bus.dc_resp_valid, bus.ic_resp_valid, bus.outstanding);
        end
        step();
        idle();
    endtask

    task automatic test_async_reset();
        do_reset();
        bus.ic_req_valid      = 1'b1;
        bus.ic_req_addr       = 32'h80;
        bus.mem2proc_response = 4'd2;
        step();
        idle();
        bus.dc_req_command    = BUS_LOAD;
        bus.dc_req_addr       = 32'h400;
        bus.mem2proc_response = 4'd4;
        step();
        idle();
        #1;
        checks++;
        if (bus.outstanding !== 5'd2) begin
            errs++;
            $display("FAIL areset_pre: got %0d want 2", bus.outstanding);
        end
        #1;
        reset = 1'b1;
        model_clear();
        #1;
        checks++;
        if ({bus.outstanding, bus.tag_err, bus.dc_owns_bus, bus.proc2mem_command}
            !== 9'd0) begin
            errs++;
            $display("FAIL areset_clear: got out%0d err%0b own%0b cmd%0d want 0",
                     bus.outstanding, bus.tag_err, bus.dc_owns_bus,
                     bus.proc2mem_command);
        end
        #1;
        reset = 1'b0;
        @(posedge clock);
        #1;
        for (int k = 0; k < 2; k++) begin
            bus.mem2proc_tag  = (k == 0) ? 4'd2 : 4'd4;
            bus.mem2proc_data = 64'hABCD;
            #1;
            checks++;
            if ({bus.ic_resp_valid, bus.dc_resp_valid} !== 2'b00) begin
                errs++;
                $display("FAIL areset_route k%0d: got %b want 00",
                         k, {bus.ic_resp_valid, bus.dc_resp_valid});
            end
            step();
            idle();
            #1;
            checks++;
            if (bus.tag_err !== 1'b1) begin
                errs++;
                $display("FAIL areset_err k%0d: got %0b want 1", k, bus.tag_err);
            end
        end
    endtask

    task automatic test_random();
        int q[$];
        do_reset();
        for (int c = 0; c < 400; c++) begin
            bus.ic_req_valid      = ($urandom_range(0, 99) < 60);
            bus.ic_req_addr       = $urandom & 32'hFFFF_FFF8;
            bus.dc_req_command    = BUS_COMMAND'($urandom_range(0, 2));
            bus.dc_req_addr       = $urandom;
            bus.dc_req_data       = {$urandom, $urandom};
            bus.mem2proc_response = ($urandom_range(0, 99) < 70) ?
                                    4'($urandom_range(1, 15)) : 4'd0;
            bus.mem2proc_data     = {$urandom, $urandom};
            q.delete();
            for (int i = 1; i < 16; i++) if (mv[i]) q.push_back(i);
            if ($urandom_range(0, 1) == 0) bus.mem2proc_tag = 4'd0;
            else if (q.size() > 0 && $urandom_range(0, 9) < 8)
                bus.mem2proc_tag = 4'(q[$urandom_range(0, q.size() - 1)]);
            else bus.mem2proc_tag = 4'($urandom_range(1, 15));
            #1;
            model_eval();
            checks++;
            if ({bus.proc2mem_command, bus.proc2mem_addr, bus.proc2mem_data}
                !== {e_cmd, e_addr, e_pdata}) begin
                errs++;
                $display("FAIL rnd_bus c%0d: got %0d/%0h/%0h want %0d/%0h/%0h", c,
                         bus.proc2mem_command, bus.proc2mem_addr, bus.proc2mem_data,
                         e_cmd, e_addr, e_pdata);
            end
            checks++;
            if ({bus.ic_req_accept, bus.ic_req_tag, bus.dc_req_accept, bus.dc_req_tag,
                 bus.dc_owns_bus} !== {e_ica, e_ict, e_dca, e_dct, e_own}) begin
                errs++;
                $display("FAIL rnd_req c%0d: got %b want %b", c,
                         {bus.ic_req_accept, bus.ic_req_tag, bus.dc_req_accept,
                          bus.dc_req_tag, bus.dc_owns_bus},
                         {e_ica, e_ict, e_dca, e_dct, e_own});
            end
            checks++;
            if ({bus.ic_resp_valid, bus.ic_resp_tag, bus.ic_resp_data,
                 bus.dc_resp_valid, bus.dc_resp_tag, bus.dc_resp_data}
                !== {e_icr, e_icrt, e_icrd, e_dcr, e_dcrt, e_dcrd}) begin
                errs++;
                $display("FAIL rnd_resp c%0d: got ic %0b/%0d dc %0b/%0d want ic %0b/%0d dc %0b/%0d",
                         c, bus.ic_resp_valid, bus.ic_resp_tag, bus.dc_resp_valid,
                         bus.dc_resp_tag, e_icr, e_icrt, e_dcr, e_dcrt);
            end
            checks++;
            if ({bus.outstanding, bus.tag_err} !== {e_out, e_err}) begin
                errs++;
                $display("FAIL rnd_state c%0d: got out%0d err%0b want out%0d err%0b",
                         c, bus.outstanding, bus.tag_err, e_out, e_err);
            end
            model_commit();
            @(posedge clock);
            #1;
        end
        idle();
    endtask

    initial begin
        model_clear();
        test_reset();
        test_dc_load();
        test_starve();
        test_store();
        test_reject();
        test_same_tag();
        test_async_reset();
        test_random();
        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end
endmodule

// File: doc/mem_bus_arbiter.md
# mem_bus_arbiter

Shares the single processor–memory port between the instruction cache (fetch fills) and the data cache (loads/stores). Replaces the ad-hoc rule "fetch stalls whenever the D-cache drives a bus command" with explicit arbitration. The arbiter tracks ownership of outstanding memory tags and routes returning data to the correct requester. Priority goes to the D-cache, with a starvation counter that guarantees fetch forward progress.

## Interface
- `STARVE_LIMIT`, default 4: consecutive cycles an I-cache request may lose before it wins priority.
- `NUM_TAGS`, default 15: memory tags 1..15 are legal; tag 0 means "none".
- `clock` in 1: single clock.
- `reset` in 1: asynchronous, active-high.
- `ic_req_valid` in 1: I-cache requests a 64-bit line load.
- `ic_req_addr` in `XLEN`: I-cache address, 8-byte aligned.
- `ic_req_accept` out 1: request accepted by memory this cycle.
- `ic_req_tag` out 4: tag assigned on accept, 0 otherwise.
- `ic_resp_valid` out 1: returning data belongs to the I-cache.
- `ic_resp_tag` out 4: tag of the returning data.
- `ic_resp_data` out 64: returning data.
- `dc_req_command` in 2: `BUS_NONE`/`BUS_LOAD`/`BUS_STORE`.
- `dc_req_addr` in `XLEN`: D-cache address.
- `dc_req_data` in 64: D-cache store data.
- `dc_req_accept` out 1; `dc_req_tag` out 4; `dc_resp_valid` out 1; `dc_resp_tag` out 4; `dc_resp_data` out 64: D-cache counterparts of the I-cache outputs above.
- `dc_owns_bus` out 1: D-cache is selected this cycle. This is the fetch stall source.
- `proc2mem_command` out 2; `proc2mem_addr` out `XLEN`; `proc2mem_data` out 64: memory request.
- `mem2proc_response` in 4: accept tag, same cycle; 0 means rejected.
- `mem2proc_data` in 64; `mem2proc_tag` in 4: memory data return, with tag 0 meaning no return.
- `outstanding` out 5: number of valid owner-table entries.
- `tag_err` out 1: sticky, set when a return arrives on an unowned tag.

## Operation
- **Selection** (combinational, once per cycle):
  - If only one side requests, that side wins.
  - If both request, the D-cache wins unless `starve_cnt == STARVE_LIMIT`, in which case the I-cache wins.
  - The winner drives `proc2mem_*`. An I-cache win drives `BUS_LOAD` and `proc2mem_data` = 0.
  - With no request: `BUS_NONE`, addr/data 0.
- **Accept:**
  - The winner's `*_req_accept` = (`mem2proc_response` != 0).
  - `*_req_tag` = `mem2proc_response`.
  - The loser, or a rejected winner, must hold its request. The arbiter keeps no request copy.
- **Owner table:** valid[1..15] and owner[1..15] (0 = I, 1 = D).
  - An accepted load sets valid and owner at the next edge.
  - Accepted stores are not recorded, because they return no data.
- **Return:** when `mem2proc_tag` != 0 and valid[tag]:
  - Assert `ic_resp_*` or `dc_resp_*` per owner, with data = `mem2proc_data`.
  - Clear valid at the next edge.
  - If valid[tag] == 0: no response is asserted and `tag_err` is set (sticky until reset).
- **Same tag returned and reallocated in one cycle:** the return uses the old owner; the new allocation wins the table write.
- **starve_cnt** (0..STARVE_LIMIT, saturating):
  - Increments when `ic_req_valid` is high and the I-cache is not accepted.
  - Clears on an I-cache accept, and when `ic_req_valid` is low.
- `dc_owns_bus` = D-cache selected, whether or not it is accepted.

## Timing
- Request→accept and return→response are combinational in the same cycle. The owner table and counters update on the clock edge.
- Reset (asynchronous) clears the owner table, `starve_cnt` and `tag_err`, and drives `outstanding` to 0.
- With all inputs idle, every output is 0 and `proc2mem_command` = `BUS_NONE`.
- Reset asserted mid-flight drops all ownership. A later return on a pre-reset tag sets `tag_err` and is not routed.
- Full table (15 outstanding) is legal. The memory owns tag allocation; the arbiter never blocks on occupancy.
- `outstanding` counts valid bits after the edge: an allocation and a return in the same cycle leave it unchanged.

## Structure
- The shared package holds:
  - the `BUS_NONE`/`BUS_LOAD`/`BUS_STORE` enum (existing);
  - an `OWNER_T` enum {`OWN_IC`, `OWN_DC`};
  - a `MEM_TAG_W`=4 constant.
- One sub-module, `mem_tag_table`, holds the valid and owner arrays with alloc/free ports, lookup, and the popcount output.
- Selection and the starvation counter live in the top level.

## Test plan
- D-cache load alone at 0x100, memory accepts with tag 3:
  - `dc_req_accept`=1, `dc_req_tag`=3;
  - a later return on tag 3 gives `dc_resp_valid` with the data; `outstanding` goes 1→0.
- Both request continuously with memory always accepting:
  - the D-cache wins 4 cycles, then the I-cache wins on the 5th;
  - `starve_cnt` returns to 0 and the pattern repeats.
- D-cache store accepted with tag 5:
  - no table entry is made, `outstanding` stays 0;
  - a forced return on tag 5 sets `tag_err` with no response asserted.
- Memory rejection (response 0) for 3 cycles on an I-cache request:
  - `ic_req_accept`=0 each cycle and the bus command is held;
  - on the 4th cycle the request is accepted.
- Tag 7 (I-cache owned) returns while a new D-cache load is accepted with tag 7 in the same cycle:
  - `ic_resp_valid`=1;
  - the table then shows tag 7 owned by the D-cache.
- Assert `reset` asynchronously with 2 tags outstanding:
  - outputs clear immediately and `outstanding`=0;
  - a subsequent return on either tag sets `tag_err`.
